// File: rtl/regfile_pkg.sv
// Shared register-file types and defaults.
// Used by decode, hazard unit and regfile_mp.
package regfile_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;
  localparam int ZERO_REG = 0;

  typedef logic [4:0]  reg_addr_t;
  typedef logic [31:0] word_t;

endpackage

// File: rtl/regfile_mp_if.sv
// Register-file port bundle: write, read, issue, flush.
// master = pipeline side, slave = regfile_mp.
interface regfile_mp_if
  import regfile_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREG  = NREG_DEF,
  parameter int NREAD = 2
) ();

  localparam int AW = $clog2(NREG);

  logic                        wr_en;
  logic [AW-1:0]               wr_addr;
  logic [XLEN-1:0]             wr_data;
  logic [NREAD-1:0][AW-1:0]    rd_addr;
  logic [NREAD-1:0][XLEN-1:0]  rd_data;
  logic [NREAD-1:0]            rd_busy;
  logic                        iss_en;
  logic [AW-1:0]               iss_rd;
  logic                        flush;
  logic                        any_busy;

  modport master (
    output wr_en, wr_addr, wr_data,
    output rd_addr, iss_en, iss_rd, flush,
    input  rd_data, rd_busy, any_busy
  );

  modport slave (
    input  wr_en, wr_addr, wr_data,
    input  rd_addr, iss_en, iss_rd, flush,
    output rd_data, rd_busy, any_busy
  );

endinterface

// File: rtl/rf_scoreboard.sv
// Busy bit per register; set on issue, clear on writeback.
// Ports: clk, rst_n, set/clr strobes+index, flush, busy, any_busy.
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREG = NREG_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    set_en,
  input  logic [$clog2(NREG)-1:0] set_idx,
  input  logic                    clr_en,
  input  logic [$clog2(NREG)-1:0] clr_idx,
  input  logic                    flush,
  output logic [NREG-1:0]         busy,
  output logic                    any_busy
);

  localparam int AW = $clog2(NREG);
  localparam logic [AW-1:0] R0 = AW'(ZERO_REG);

  logic set_ok;
  logic clr_ok;

  assign set_ok = set_en && (set_idx != R0);
  assign clr_ok = clr_en && (clr_idx != R0);

  // Set is applied after clear so a new producer
  // on the retiring index keeps the bit set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else if (flush) begin
      busy <= '0;
    end else begin
      if (clr_ok) busy[clr_idx] <= 1'b0;
      if (set_ok) busy[set_idx] <= 1'b1;
    end
  end

  assign any_busy = |busy;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with busy scoreboard.
// Ports: clk, rst_n, rf (regfile_mp_if.slave bundle).
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREG   = NREG_DEF,
  parameter int NREAD  = 2,
  parameter int BYPASS = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  regfile_mp_if.slave  rf
);

  localparam int AW = $clog2(NREG);
  localparam logic [AW-1:0] R0 = AW'(ZERO_REG);

  logic [XLEN-1:0] mem [NREG];
  logic [NREG-1:0] busy;
  logic            wr_ok;

  assign wr_ok = rf.wr_en && (rf.wr_addr != R0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (wr_ok) begin
      mem[rf.wr_addr] <= rf.wr_data;
    end
  end

  rf_scoreboard #(
    .NREG (NREG)
  ) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (rf.iss_en),
    .set_idx  (rf.iss_rd),
    .clr_en   (rf.wr_en),
    .clr_idx  (rf.wr_addr),
    .flush    (rf.flush),
    .busy     (busy),
    .any_busy (rf.any_busy)
  );

  // Outputs forced to zero during reset so a bypassed
  // write cannot leak through while rst_n is low.
  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [AW-1:0] a;
    logic          hit;
    logic          live;

    assign a    = rf.rd_addr[k];
    assign live = rst_n && (a != R0);
    assign hit  = (BYPASS != 0) && wr_ok
               && (rf.wr_addr == a);

    assign rf.rd_data[k] = !live ? '0
                         : hit   ? rf.wr_data
                         :         mem[a];

    // Retiring write hides busy unless re-issued now.
    assign rf.rd_busy[k] = live && busy[a]
      && !(hit && !(rf.iss_en && rf.iss_rd == a));
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised integer register file for the pipelined RV32I core.
- Provides NREAD combinational read ports and one synchronous write port.
- Optional write-to-read bypass removes the WB→ID forwarding path.
- Integrated busy scoreboard lets the hazard unit detect reads of registers whose producer has not yet written back; all state is cleared on reset.

Parameters:
- XLEN, 32, data width in bits.
- NREG, 32, number of architectural registers (power of two, ≥2); register 0 hardwired to zero.
- NREAD, 2, number of independent read ports (1..4).
- BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports; 0 = reads return stored value only.

Ports:
- clk  in  1  clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  write enable (WB stage).
- wr_addr  in  $clog2(NREG)  destination register.
- wr_data  in  XLEN  data to write.
- rd_addr  in  NREAD×$clog2(NREG)  read addresses, port k at slice k.
- rd_data  out  NREAD×XLEN  read data, port k at slice k.
- rd_busy  out  NREAD  port k's register has an outstanding producer.
- iss_en  in  1  instruction with a destination issued this cycle (ID→EX).
- iss_rd  in  $clog2(NREG)  destination of issuing instruction.
- flush  in  1  pipeline flush: clear all busy bits.
- any_busy  out  1  OR of all busy bits (drain indicator).

Behaviour:
- Reset (rst_n=0, async): all NREG registers ← 0, all busy bits ← 0. While in reset rd_data=0, rd_busy=0, any_busy=0.
- Write: at posedge clk, if wr_en && wr_addr≠0, reg[wr_addr] ← wr_data. Writes to register 0 are ignored.
- Read: combinational, zero latency.
  - rd_data[k] = 0 if rd_addr[k]==0.
  - Otherwise, with BYPASS=1 and wr_en && wr_addr==rd_addr[k]≠0, rd_data[k] = wr_data (new value visible the same cycle).
  - Otherwise rd_data[k] = reg[rd_addr[k]].
  - With BYPASS=0 the new value is visible on the cycle after the write edge.
- Scoreboard: one busy bit per register; bit 0 is constant 0.
  - Set on posedge when iss_en && iss_rd≠0.
  - Cleared on posedge when wr_en && wr_addr≠0 and not simultaneously set for the same index.
  - Same index both set and cleared in one cycle → stays set; the new producer wins.
  - Different indices: both take effect.
  - flush=1 at posedge: all busy bits ← 0, overriding any same-cycle set. The register write in that cycle still occurs.
- rd_busy[k] = busy[rd_addr[k]], except when BYPASS=1 and the same-cycle write to that index clears it (wr_en && wr_addr==rd_addr[k]) with no same-cycle issue to it; then rd_busy[k]=0.
- any_busy = |busy, registered view (no bypass).
- Single write port only. Multiple ports reading the same address return identical data.
- Mid-operation reset discards register contents and scoreboard immediately, without waiting for a clock edge.
- Out-of-range addresses cannot occur because NREG is a power of two.

Decomposition:
- Package regfile_pkg:
  - XLEN_DEF=32, NREG_DEF=32, constant ZERO_REG=0.
  - typedefs reg_addr_t (logic [4:0]) and word_t (logic [31:0]) used by decode, hazard unit and this block.
- One sub-module, rf_scoreboard:
  - Busy-bit vector, set/clear/flush priority, any_busy.
  - Parametrised by NREG; instantiated once.
- Storage array, read muxes and bypass stay in regfile_mp.

Test Plan:
- Reset, then read all 32 addresses on both ports → every rd_data=0, rd_busy=0. Assert rst_n=0 mid-run after writing x5=0xDEADBEEF → rd_data for x5 becomes 0 before the next clk edge.
- Write x0=0xFFFFFFFF with wr_en=1, read x0 → 0. iss_en with iss_rd=0 → rd_busy=0, any_busy=0.
- BYPASS=1: same cycle wr_en, wr_addr=7, wr_data=0x12345678 and rd_addr[1]=7 → rd_data[1]=0x12345678 in that cycle. BYPASS=0, same stimulus → old value 0 this cycle, 0x12345678 the next.
- Issue iss_rd=3, next cycle read x3 → rd_busy=1, any_busy=1. Write back x3=0xA5 → BYPASS=1 rd_busy=0 that cycle, busy cleared after the edge, any_busy=0.
- Same cycle iss_en/iss_rd=9 and wr_en/wr_addr=9 with x9 already busy → x9 busy remains 1 after the edge. Same cycle iss_rd=4 and wr_addr=9 → x4 busy=1, x9 busy=0.
- Busy x2, x6, x10, then flush=1 together with iss_rd=12 → all busy=0 after the edge including x12, any_busy=0. A same-cycle wr_en x6=0x55 is still written (reads 0x55).
